// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU slice.
//   - default operand width and op-code width
//   - datapath op-code encoding (ADD, OR, SLLI, SRLI, SUB, MUL)
//   - FSM state encoding for alu_multicycle_unit
// Optional feature macro: ALU_MULTICYCLE_MUL_EN adds the MUL state.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OP_W  = 4;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_SLLI = 4'b0010;
    localparam logic [3:0] OP_SRLI = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_SHIFT = 3'd2,
`ifdef ALU_MULTICYCLE_MUL_EN
        S_MUL   = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_iter_shifter.sv
// alu_iter_shifter: iterative barrel-free shifter, one bit position per cycle.
// Loaded with a value, a shift amount and a direction; then shifts once per
// cycle while its down-counter is non-zero. done_o is high whenever no shift
// steps remain (including right after a load with shamt 0).
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   load_i      capture data_i / shamt_i / left_i this cycle
//   left_i      1 = logical left shift, 0 = logical right shift (zero fill)
//   data_i      value to shift
//   shamt_i     number of single-bit steps to perform
//   data_o      current shift register contents
//   done_o      1 when the down-counter has reached zero
module alu_iter_shifter #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_i,
    input  logic                     left_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic [$clog2(WIDTH)-1:0] shamt_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     done_o
);

    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0] data_q;
    logic [SH_W-1:0]  cnt_q;
    logic             left_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
        end else if (load_i) begin
            data_q <= data_i;
            cnt_q  <= shamt_i;
            left_q <= left_i;
        end else if (cnt_q != '0) begin
            if (left_q) begin
                data_q <= {data_q[WIDTH-2:0], 1'b0};
            end else begin
                data_q <= {1'b0, data_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q - SH_W'(1);
        end
    end

    assign data_o = data_q;
    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alu_multicycle_unit.sv
// alu_multicycle_unit: handshaked multi-cycle ALU responder.
// Accepts one request at a time in IDLE, captures op/operands, evaluates
// (single step for ADD/OR/SUB/unknown, 1 bit/cycle for shifts, shift-add for
// MUL) and presents a registered result until the consumer accepts it.
// Latency accept-edge -> rsp_valid_o: 2, 2+shamt (shifts), 2+WIDTH (MUL).
// Optional feature macro: ALU_MULTICYCLE_MUL_EN enables op 0101 = MUL; when
// undefined, 0101 is treated as an unknown op.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   req_valid_i  request valid          req_ready_o  high only in IDLE
//   op_i         operation code         a_i, b_i     operands (b_i = shamt)
//   rsp_valid_o  result valid (held)    rsp_ready_i  consumer accepts result
//   result_o     registered result      zero_o       result_o == 0
//   busy_o       high in SHIFT/MUL/DONE
module alu_multicycle_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OP_W  = ALU_OP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             fin_q, fin_d;
    logic [WIDTH-1:0] res_sel;

    logic             accept;
    logic             shift_op_in;
    logic [SH_W-1:0]  shamt_in;
    logic [WIDTH-1:0] shift_data;
    logic             shift_done;

    assign accept      = req_valid_i && (state_q == S_IDLE);
    assign shamt_in    = b_i[SH_W-1:0];
    assign shift_op_in = (op_i == OP_W'(OP_SLLI)) || (op_i == OP_W'(OP_SRLI));

    alu_iter_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept && shift_op_in),
        .left_i  (op_i == OP_W'(OP_SLLI)),
        .data_i  (a_i),
        .shamt_i (shamt_in),
        .data_o  (shift_data),
        .done_o  (shift_done)
    );

`ifdef ALU_MULTICYCLE_MUL_EN
    logic [WIDTH-1:0] mul_acc_q, mul_mcand_q, mul_mplier_q;
    logic [SH_W:0]    mul_cnt_q;

    // Unsigned shift-add: exactly WIDTH iterations, low WIDTH bits kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            mul_cnt_q    <= '0;
        end else if (accept && (op_i == OP_W'(OP_MUL))) begin
            mul_acc_q    <= '0;
            mul_mcand_q  <= a_i;
            mul_mplier_q <= b_i;
            mul_cnt_q    <= (SH_W+1)'(WIDTH);
        end else if ((state_q == S_MUL) && (mul_cnt_q != '0)) begin
            if (mul_mplier_q[0]) begin
                mul_acc_q <= mul_acc_q + mul_mcand_q;
            end
            mul_mcand_q  <= {mul_mcand_q[WIDTH-2:0], 1'b0};
            mul_mplier_q <= {1'b0, mul_mplier_q[WIDTH-1:1]};
            mul_cnt_q    <= mul_cnt_q - (SH_W+1)'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every working state spends one extra "commit" cycle (fin_q high) after
    // its value is ready; DONE is entered on the following edge and the
    // response register is loaded then, giving the uniform 2+n latency.
    always_comb begin
        state_d     = state_q;
        fin_d       = 1'b0;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (shift_op_in && (shamt_in != '0)) begin
                        state_d = S_SHIFT;
                    end
`ifdef ALU_MULTICYCLE_MUL_EN
                    else if (op_i == OP_W'(OP_MUL)) begin
                        state_d = S_MUL;
                    end
`endif
                    else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (fin_q) begin
                    state_d = S_DONE;
                end else begin
                    fin_d = 1'b1;
                end
            end
            S_SHIFT: begin
                busy_o = 1'b1;
                if (fin_q) begin
                    state_d = S_DONE;
                end else begin
                    fin_d = shift_done;
                end
            end
`ifdef ALU_MULTICYCLE_MUL_EN
            S_MUL: begin
                busy_o = 1'b1;
                if (fin_q) begin
                    state_d = S_DONE;
                end else begin
                    fin_d = (mul_cnt_q == '0);
                end
            end
`endif
            S_DONE: begin
                busy_o      = 1'b1;
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result source selected from the captured op code.
    always_comb begin
        res_sel = '0;
        case (op_q)
            OP_W'(OP_ADD):  res_sel = a_q + b_q;
            OP_W'(OP_OR):   res_sel = a_q | b_q;
            OP_W'(OP_SUB):  res_sel = a_q - b_q;
            // shamt 0 bypasses SHIFT, so the operand passes straight through
            OP_W'(OP_SLLI),
            OP_W'(OP_SRLI): res_sel = (state_q == S_SHIFT) ? shift_data : a_q;
`ifdef ALU_MULTICYCLE_MUL_EN
            OP_W'(OP_MUL):  res_sel = mul_acc_q;
`endif
            default:        res_sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            fin_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            fin_q <= fin_d;
            if (accept) begin
                op_q <= op_i;
                a_q  <= a_i;
                b_q  <= b_i;
            end
            if (fin_q) begin
                result_q <= res_sel;
                zero_q   <= (res_sel == '0);
            end
        end
    end

    assign result_o = result_q;
    assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_multicycle_unit.sv
// tb_alu_multicycle_unit: self-checking bench for alu_multicycle_unit.
// Directed cases plus randomized requests checked against a plain-arithmetic
// reference model of the result and latency. Honours ALU_MULTICYCLE_MUL_EN.
module tb_alu_multicycle_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready_o;
    logic [3:0]  op_in;
    logic [31:0] a_in, b_in;
    logic        rsp_valid_o;
    logic        rsp_ready;
    logic [31:0] result_o;
    logic        zero_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_multicycle_unit #(
        .WIDTH (32),
        .OP_W  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .op_i        (op_in),
        .a_i         (a_in),
        .b_i         (b_in),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .result_o    (result_o),
        .zero_o      (zero_o),
        .busy_o      (busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b[4:0];
        case (op)
            4'd0: return a + b;
            4'd1: return a | b;
            4'd2: return a << sh;
            4'd3: return a >> sh;
            4'd4: return a - b;
`ifdef ALU_MULTICYCLE_MUL_EN
            4'd5: return a * b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd2 || op == 4'd3) return 2 + int'(b[4:0]);
`ifdef ALU_MULTICYCLE_MUL_EN
        if (op == 4'd5) return 2 + 32;
`endif
        return 2;
    endfunction

    // One transaction: issue, measure latency, check result, optionally hold
    // the response under backpressure for `hold` cycles, then retire it.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit early);
        logic [31:0] exp_r;
        int          exp_l;
        int          lat;
        exp_r = ref_result(op, a, b);
        exp_l = ref_latency(op, b);
        @(negedge clk);
        check_eq("req_ready_idle", 32'(req_ready_o), 32'd1);
        req_valid = 1'b1;
        op_in     = op;
        a_in      = a;
        b_in      = b;
        rsp_ready = early;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op_in     = 4'($urandom);
        a_in      = $urandom;
        b_in      = $urandom;
        lat = 0;
        while (!rsp_valid_o && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_l));
        if (!rsp_valid_o) return;
        check_eq("result", result_o, exp_r);
        check_eq("zero", 32'(zero_o), 32'(exp_r == 32'd0));
        check_eq("busy_done", 32'(busy_o), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            op_in     = 4'($urandom_range(0, 1));
            a_in      = $urandom;
            b_in      = $urandom;
            @(posedge clk);
            #1;
            check_eq("hold_valid", 32'(rsp_valid_o), 32'd1);
            check_eq("hold_result", result_o, exp_r);
            check_eq("hold_ready", 32'(req_ready_o), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("retire_valid", 32'(rsp_valid_o), 32'd0);
        check_eq("retire_ready", 32'(req_ready_o), 32'd1);
        check_eq("retire_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rises;
        logic [3:0]  rop;
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        op_in     = '0;
        a_in      = '0;
        b_in      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_valid", 32'(rsp_valid_o), 32'd0);
        check_eq("rst_result", result_o, 32'd0);
        check_eq("rst_zero", 32'(zero_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_ready", 32'(req_ready_o), 32'd1);

        run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 0, 1'b1);
        run_op(4'd4, 32'd5, 32'd5, 0, 1'b1);
        run_op(4'd4, 32'd0, 32'd1, 0, 1'b0);
        run_op(4'd2, 32'd1, 32'd31, 0, 1'b1);
        run_op(4'd3, 32'h8000_0000, 32'h23, 0, 1'b1);
        run_op(4'd2, 32'h0000_ABCD, 32'd0, 0, 1'b1);
        run_op(4'd1, 32'h0000_00F0, 32'h0000_000F, 10, 1'b0);
        run_op(4'd9, 32'd123, 32'd456, 0, 1'b1);

        // Abort a long shift with reset; no response may follow.
        @(negedge clk);
        req_valid = 1'b1;
        op_in     = 4'd2;
        a_in      = 32'd1;
        b_in      = 32'd20;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_ready", 32'(req_ready_o), 32'd1);
        check_eq("abort_busy", 32'(busy_o), 32'd0);
        check_eq("abort_valid", 32'(rsp_valid_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rises = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rsp_valid_o) rises++;
        end
        check_eq("abort_no_rsp", 32'(rises), 32'd0);
        run_op(4'd0, 32'd2, 32'd3, 0, 1'b1);

        run_op(4'd5, 32'd6, 32'd7, 0, 1'b1);

        for (int k = 0; k < 30; k++) begin
            rop = 4'($urandom_range(0, 8));
            if (rop == 4'd8) rop = 4'($urandom_range(6, 15));
            if ($urandom_range(0, 1) == 1)
                run_op(rop, $urandom, $urandom, 0, 1'b1);
            else
                run_op(rop, $urandom, $urandom, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
